// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter/sequencer sharing one W-bit falling-edge register among
// four requesters. One owner at a time, at most HOLD loads per ownership,
// priority rotates to the requester after the last owner.
module rr_reg_arbiter #(
    parameter int W    = 4,
    parameter int HOLD = 4
) (
    input  logic           c,
    input  logic           re,
    input  logic [3:0]     req,
    input  logic [4*W-1:0] d,
    output logic [3:0]     gnt,
    output logic [W-1:0]   q,
    output logic           qv,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_CNT = 4'(HOLD);

    state_t       r_state;
    state_t       w_nextState;
    logic [1:0]   r_ptr;
    logic [1:0]   w_nextPtr;
    logic [1:0]   r_own;
    logic [1:0]   w_nextOwn;
    logic [3:0]   r_cnt;
    logic [3:0]   w_nextCnt;
    logic [1:0]   w_winner;
    logic         w_anyReq;
    logic         w_load;
    logic [W-1:0] r_q;
    logic         r_qv;

    // Find the first requester at or after the priority pointer (descending scan so the closest one wins).
    always_comb begin
        logic [1:0] idx;
        w_winner = r_ptr;
        w_anyReq = |req;
        for (int k = 3; k >= 0; k--) begin
            idx = r_ptr + 2'(k);
            if (req[idx]) begin
                w_winner = idx;
            end
        end
    end

    // Next-state logic: arbitrate in IDLE, count loads in OWN, spend one cycle in GAP.
    always_comb begin
        w_nextState = r_state;
        w_nextPtr   = r_ptr;
        w_nextOwn   = r_own;
        w_nextCnt   = r_cnt;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_anyReq) begin
                    w_nextState = OWN;
                    w_nextOwn   = w_winner;
                    w_nextCnt   = 4'd1;
                end
            end
            OWN: begin
                if (req[r_own]) begin
                    w_load = 1'b1;
                    if (r_cnt == HOLD_CNT) begin
                        w_nextState = GAP;
                        w_nextPtr   = r_own + 2'd1;
                    end else begin
                        w_nextCnt = r_cnt + 4'd1;
                    end
                end else begin
                    w_nextState = GAP;
                    w_nextPtr   = r_own + 2'd1;
                end
            end
            GAP: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Control state registers, updated on the falling edge like the shared register itself.
    always_ff @(negedge c or negedge re) begin
        if (!re) begin
            r_state <= IDLE;
            r_ptr   <= 2'd0;
            r_own   <= 2'd0;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_nextState;
            r_ptr   <= w_nextPtr;
            r_own   <= w_nextOwn;
            r_cnt   <= w_nextCnt;
        end
    end

    // Shared register: load the owner's slice on granted edges with req still high; qv marks that load.
    always_ff @(negedge c or negedge re) begin
        if (!re) begin
            r_q  <= '0;
            r_qv <= 1'b0;
        end else begin
            if (w_load) begin
                r_q <= d[r_own*W +: W];
            end
            r_qv <= w_load;
        end
    end

    assign gnt  = (r_state == OWN) ? (4'b0001 << r_own) : 4'b0000;
    assign busy = (r_state != IDLE);
    assign q    = r_q;
    assign qv   = r_qv;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Self-checking bench for rr_reg_arbiter: directed scenarios plus randomized
// requests, all compared against an ownership-level reference model.
module tb_rr_reg_arbiter;

    localparam int W    = 4;
    localparam int HOLD = 4;
    localparam int DW   = 4 * W;

    logic          c;
    logic          re;
    logic [3:0]    req;
    logic [DW-1:0] d;
    logic [3:0]    gnt;
    logic [W-1:0]  q;
    logic          qv;
    logic          busy;

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the register, how many loads it has made,
    // whether the mandatory idle gap is pending, and whose turn is first.
    int           mOwner;
    int           mLoads;
    bit           mGap;
    int           mPtr;
    logic [W-1:0] mQ;
    bit           mQv;

    rr_reg_arbiter #(.W(W), .HOLD(HOLD)) dut (
        .c    (c),
        .re   (re),
        .req  (req),
        .d    (d),
        .gnt  (gnt),
        .q    (q),
        .qv   (qv),
        .busy (busy)
    );

    // Free-running clock; the design acts on falling edges, the bench samples on rising edges.
    initial begin
        c = 1'b0;
        forever #5 c = ~c;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mOwner = -1;
        mLoads = 0;
        mGap   = 0;
        mPtr   = 0;
        mQ     = '0;
        mQv    = 0;
    endtask

    task automatic modelRelease();
        mPtr   = (mOwner + 1) % 4;
        mOwner = -1;
        mGap   = 1;
    endtask

    // Advance the model by one falling edge with the given inputs.
    task automatic modelStep(input logic [3:0] reqV, input logic [DW-1:0] dV);
        if (mGap) begin
            mGap = 0;
            mQv  = 0;
        end else if (mOwner < 0) begin
            mQv = 0;
            for (int k = 0; k < 4; k++) begin
                if (mOwner < 0 && reqV[(mPtr + k) % 4]) begin
                    mOwner = (mPtr + k) % 4;
                    mLoads = 0;
                end
            end
        end else if (reqV[mOwner]) begin
            mQ  = dV[mOwner*W +: W];
            mQv = 1;
            mLoads++;
            if (mLoads == HOLD) modelRelease();
        end else begin
            mQv = 0;
            modelRelease();
        end
    endtask

    task automatic compareModel(input string tag);
        logic [3:0] expGnt;
        expGnt = (mOwner >= 0) ? (4'b0001 << mOwner) : 4'b0000;
        checkOutput({tag, "_gnt"}, 32'(gnt), 32'(expGnt));
        checkOutput({tag, "_q"}, 32'(q), 32'(mQ));
        checkOutput({tag, "_qv"}, 32'(qv), 32'(mQv));
        checkOutput({tag, "_busy"}, 32'(busy), 32'((mOwner >= 0) || mGap));
    endtask

    // One cycle: drive inputs, scramble d between edges, then compare after the next rising edge.
    task automatic applyStimulus(input logic [3:0] reqV, input logic [DW-1:0] dV, input string tag);
        req = reqV;
        d   = dV;
        modelStep(reqV, dV);
        @(negedge c);
        #1 d = DW'($urandom);
        @(posedge c);
        compareModel(tag);
    endtask

    task automatic doReset(input string tag);
        re = 1'b0;
        #1;
        checkOutput({tag, "_rst_gnt"}, 32'(gnt), 32'h0);
        checkOutput({tag, "_rst_q"}, 32'(q), 32'h0);
        checkOutput({tag, "_rst_qv"}, 32'(qv), 32'h0);
        checkOutput({tag, "_rst_busy"}, 32'(busy), 32'h0);
        modelReset();
        @(posedge c);
        re = 1'b1;
    endtask

    // Main sequence: directed scenarios first, then a long randomized run.
    initial begin
        logic [3:0] expSingle [7];
        logic [3:0] rrOrder   [5];
        logic [3:0] seen [$];
        logic [3:0] prevGnt;
        logic [3:0] reqV;
        int         qvCount;

        expSingle = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100};
        rrOrder   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        re  = 1'b1;
        req = 4'b0000;
        d   = '0;
        modelReset();
        #1;
        doReset("init");

        // Reset while owning with q=A, then all-request arbitration restarts at requester 0.
        applyStimulus(4'b0001, 16'h000A, "rstA_grant");
        applyStimulus(4'b0001, 16'h000A, "rstA_load");
        checkOutput("rstA_q_before", 32'(q), 32'hA);
        #2;
        doReset("midown");
        applyStimulus(4'b1111, DW'($urandom), "rstA_after");
        checkOutput("rstA_first_gnt", 32'(gnt), 32'b0001);

        // Single requester held continuously.
        doReset("single");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(4'b0100, 16'h0500, "single");
            checkOutput("single_gnt_seq", 32'(gnt), 32'(expSingle[i]));
        end
        checkOutput("single_q", 32'(q), 32'h5);

        // Everyone requesting: ownership rotates 0,1,2,3,0.
        doReset("rr");
        prevGnt = 4'b0000;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(4'b1111, DW'($urandom), "rr");
            if (gnt != 4'b0000 && prevGnt == 4'b0000) seen.push_back(gnt);
            prevGnt = gnt;
        end
        checkOutput("rr_count", 32'(seen.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < seen.size()) checkOutput("rr_order", 32'(seen[i]), 32'(rrOrder[i]));
        end

        // Owner 1 drops its request after two loads; the pointer moves on to 2.
        doReset("early");
        qvCount = 0;
        applyStimulus(4'b0010, 16'h0030, "early");
        applyStimulus(4'b0010, 16'h0030, "early");
        qvCount += int'(qv);
        applyStimulus(4'b0010, 16'h0030, "early");
        qvCount += int'(qv);
        applyStimulus(4'b0000, 16'h0070, "early");
        qvCount += int'(qv);
        checkOutput("early_gap_busy", 32'(busy), 32'h1);
        applyStimulus(4'b1111, 16'h00F0, "early");
        qvCount += int'(qv);
        checkOutput("early_q", 32'(q), 32'h3);
        checkOutput("early_qv_pulses", 32'(qvCount), 32'd2);
        applyStimulus(4'b1111, 16'h0000, "early");
        checkOutput("early_next_gnt", 32'(gnt), 32'b0100);

        // Owner 2 drops its request exactly on the edge that would be its last load.
        for (int i = 1; i < HOLD; i++) begin
            applyStimulus(4'b0100, DW'(i << 8), "coll");
        end
        applyStimulus(4'b0000, 16'h0C00, "coll");
        checkOutput("coll_qv", 32'(qv), 32'h0);
        checkOutput("coll_q", 32'(q), 32'(HOLD - 1));
        checkOutput("coll_gnt", 32'(gnt), 32'h0);

        // Randomized requests with persistence so full and partial ownerships both occur.
        doReset("rand");
        reqV = 4'b1111;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) reqV = 4'($urandom);
            applyStimulus(reqV, DW'($urandom), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
